// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared constants and types for the pipeline hazard controller.
//             MIPS opcode/funct values that trigger mult/div hazards, the
//             controller FSM encoding, and a counter-width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      FLUSH    = 2'd2
   } hz_state_t;

   // Bits needed to hold values 0..max_val; never less than one bit so a
   // zero-valued parameter still yields a legal vector.
   function automatic int cnt_w(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_downcnt.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_downcnt
//  Purpose  : Loadable down counter that stops at zero. Used for the load
//             bubble count, the post-redirect flush count and the mult/div
//             busy window.
//  Ports    : Clk      - clock, rising edge
//             Reset    - synchronous active-high clear
//             load     - load load_val on the next edge (wins over dec)
//             load_val - value to load
//             dec      - decrement on the next edge (holds at zero)
//             zero     - counter currently zero
//             last     - counter currently one (final active cycle)
//  Revision : 1.0  initial release
// ============================================================================
module hazard_downcnt #(
   parameter int W = 1
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero,
   output logic         last
);

   localparam logic [W-1:0] C_ONE = W'(1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - C_ONE;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);
   assign last = (count_q == C_ONE);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_v2
//  Purpose  : Pipeline hazard controller for the 5-stage MIPS datapath.
//             Inserts multi-cycle load-use bubbles, blocks mult/div-dependent
//             instructions during the busy window and flushes IF/ID (and
//             ID/EX on the redirect cycle) after a control redirect.
//             All hazard outputs are combinational from state and inputs.
//  Ports    : Clk, Reset           - clock / synchronous active-high reset
//             IF_ID_Instr          - instruction in ID
//             ID_EX_Rt             - destination register of the EX instr
//             ID_EX_MemRead        - EX instruction is a load
//             MD_Start             - mult/div issued from EX this cycle
//             Redirect             - EX resolved a control transfer
//             PCWrite, IF_ID_Write - pipeline front-end enables
//             IF_ID_Flush          - zero IF/ID on the next edge
//             ID_EX_Flush          - bubble into ID/EX on the next edge
//             StallActive          - a stall bubble is inserted this cycle
//             StallCount           - saturating stall-cycle count (option)
//             FlushCount           - saturating redirect count (option)
//  Option   : define HAZARD_STATS_EN to add StallCount/FlushCount.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_v2
   import hazard_pkg::*;
#(
   parameter int REG_W       = 5,
   parameter int LOAD_STALL  = 1,
   parameter int MD_LAT      = 4,
   parameter int EXTRA_FLUSH = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [31:0]      IF_ID_Instr,
   input  logic [REG_W-1:0] ID_EX_Rt,
   input  logic             ID_EX_MemRead,
   input  logic             MD_Start,
   input  logic             Redirect,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             StallActive
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]      StallCount,
   output logic [31:0]      FlushCount
`endif
);

   localparam int LD_W = cnt_w(LOAD_STALL);
   localparam int FL_W = cnt_w(EXTRA_FLUSH);
   localparam int MD_W = cnt_w(MD_LAT);

   // The detection cycle is the first bubble, so the FSM only counts the rest.
   localparam logic [LD_W-1:0] C_LD_RELOAD = LD_W'(LOAD_STALL - 1);
   localparam logic [FL_W-1:0] C_FL_RELOAD = FL_W'(EXTRA_FLUSH);
   localparam logic [MD_W-1:0] C_MD_RELOAD = MD_W'(MD_LAT);

   hz_state_t state_q;
   hz_state_t state_d;

   logic            ld_load, ld_dec, ld_zero, ld_last;
   logic [LD_W-1:0] ld_val;
   logic            fl_load, fl_dec, fl_zero, fl_last;
   logic            md_zero, md_last_unused;
   logic            stall;

   // ------------------------------------------------------------------
   // Instruction decode
   // ------------------------------------------------------------------
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [REG_W-1:0] rs_addr;
   logic [REG_W-1:0] rt_addr;
   logic             lu_hazard;
   logic             md_op;
   logic             md_hazard;
   logic             unused_instr_bits;

   assign opcode  = IF_ID_Instr[31:26];
   assign funct   = IF_ID_Instr[5:0];
   assign rs_addr = REG_W'(IF_ID_Instr[25:21]);
   assign rt_addr = REG_W'(IF_ID_Instr[20:16]);
   assign unused_instr_bits = ^IF_ID_Instr[15:6];

   // Register $0 is hard-wired, so a load "into" it never creates a hazard.
   assign lu_hazard = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                      ((ID_EX_Rt == rs_addr) || (ID_EX_Rt == rt_addr));

   assign md_op = (opcode == OP_RTYPE) &&
                  ((funct == FN_MFHI) || (funct == FN_MFLO) ||
                   (funct == FN_MULT) || (funct == FN_MULTU) ||
                   (funct == FN_DIV)  || (funct == FN_DIVU));

   assign md_hazard = !md_zero && md_op;

   // ------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------
   hazard_downcnt #(.W(LD_W)) u_ld_cnt (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (ld_load),
      .load_val (ld_val),
      .dec      (ld_dec),
      .zero     (ld_zero),
      .last     (ld_last)
   );

   hazard_downcnt #(.W(FL_W)) u_fl_cnt (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (fl_load),
      .load_val (C_FL_RELOAD),
      .dec      (fl_dec),
      .zero     (fl_zero),
      .last     (fl_last)
   );

   // The mult/div op is architecturally real, so its window keeps running
   // through redirects and flushes; a new issue restarts the window.
   hazard_downcnt #(.W(MD_W)) u_md_cnt (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (MD_Start),
      .load_val (C_MD_RELOAD),
      .dec      (1'b1),
      .zero     (md_zero),
      .last     (md_last_unused)
   );

   // ------------------------------------------------------------------
   // FSM next state and hazard outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      StallActive = 1'b0;
      stall       = 1'b0;
      ld_load     = 1'b0;
      ld_val      = '0;
      ld_dec      = 1'b0;
      fl_load     = 1'b0;
      fl_dec      = 1'b0;

      if (Reset) begin
         state_d = RUN;
      end else if (Redirect) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
         // Pending load bubbles belonged to a wrong-path instruction.
         ld_load     = 1'b1;
         ld_val      = '0;
         if (EXTRA_FLUSH > 0) begin
            state_d = FLUSH;
            fl_load = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else begin
         unique case (state_q)
            FLUSH: begin
               // ID holds a squashed slot: hazards against it are meaningless.
               IF_ID_Flush = 1'b1;
               fl_dec      = 1'b1;
               if (fl_last || fl_zero) begin
                  state_d = RUN;
               end
            end
            LD_STALL: begin
               stall  = 1'b1;
               ld_dec = 1'b1;
               if (ld_last || ld_zero) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (lu_hazard) begin
                  stall = 1'b1;
                  if (LOAD_STALL > 1) begin
                     state_d = LD_STALL;
                     ld_load = 1'b1;
                     ld_val  = C_LD_RELOAD;
                  end
               end else if (md_hazard) begin
                  stall = 1'b1;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end

      if (stall) begin
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
         StallActive = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef HAZARD_STATS_EN
   // ------------------------------------------------------------------
   // Saturating statistics
   // ------------------------------------------------------------------
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (StallActive && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
      if (Redirect && (flush_count_q != 32'hFFFF_FFFF)) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_count_q <= 32'd0;
         flush_count_q <= 32'd0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign StallCount = stall_count_q;
   assign FlushCount = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_v2
//  Purpose  : Directed self-checking bench for hazard_ctrl_v2 with
//             LOAD_STALL=2, MD_LAT=4, EXTRA_FLUSH=2. Each row drives one
//             cycle of inputs and states the expected output vector
//             {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, StallActive}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_v2;

   logic        Clk;
   logic        Reset;
   logic [31:0] IF_ID_Instr;
   logic [4:0]  ID_EX_Rt;
   logic        ID_EX_MemRead;
   logic        MD_Start;
   logic        Redirect;
   logic        PCWrite;
   logic        IF_ID_Write;
   logic        IF_ID_Flush;
   logic        ID_EX_Flush;
   logic        StallActive;
`ifdef HAZARD_STATS_EN
   logic [31:0] StallCount;
   logic [31:0] FlushCount;
`endif

   int total = 0;
   int bad   = 0;

   hazard_ctrl_v2 #(
      .REG_W       (5),
      .LOAD_STALL  (2),
      .MD_LAT      (4),
      .EXTRA_FLUSH (2)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .IF_ID_Instr   (IF_ID_Instr),
      .ID_EX_Rt      (ID_EX_Rt),
      .ID_EX_MemRead (ID_EX_MemRead),
      .MD_Start      (MD_Start),
      .Redirect      (Redirect),
      .PCWrite       (PCWrite),
      .IF_ID_Write   (IF_ID_Write),
      .IF_ID_Flush   (IF_ID_Flush),
      .ID_EX_Flush   (ID_EX_Flush),
      .StallActive   (StallActive)
`ifdef HAZARD_STATS_EN
      ,
      .StallCount    (StallCount),
      .FlushCount    (FlushCount)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Expected output vectors
   localparam logic [4:0] S_RUN = 5'b11000;
   localparam logic [4:0] S_STL = 5'b00011;
   localparam logic [4:0] S_RDR = 5'b11110;
   localparam logic [4:0] S_FL  = 5'b11100;

   // Instructions (R-type: op rs rt rd shamt funct)
   localparam logic [31:0] NOP     = 32'h0000_0000;
   localparam logic [31:0] ADD123  = {6'd0, 5'd2, 5'd3, 5'd1, 5'd0, 6'b100000};
   localparam logic [31:0] ADD100  = {6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'b100000};
   localparam logic [31:0] MFLO8   = {6'd0, 5'd0, 5'd0, 5'd8, 5'd0, 6'b010010};
   localparam logic [31:0] MFHI9   = {6'd0, 5'd0, 5'd0, 5'd9, 5'd0, 6'b010000};
   localparam logic [31:0] MULT45  = {6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 6'b011000};
   localparam logic [31:0] DIVU45  = {6'd0, 5'd4, 5'd5, 5'd0, 5'd0, 6'b011011};
   // ori whose immediate low bits look like a mult funct: must not stall
   localparam logic [31:0] ORI67   = {6'b001101, 5'd6, 5'd7, 16'h0018};

   typedef struct packed {
      logic        mr;
      logic [4:0]  rt;
      logic [31:0] ins;
      logic        mds;
      logic        rd;
      logic        rst;
      logic [4:0]  exp;
   } row_t;

   function automatic logic [4:0] outs();
      return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, StallActive};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic apply(input row_t r);
      tick();
      Reset         = r.rst;
      ID_EX_MemRead = r.mr;
      ID_EX_Rt      = r.rt;
      IF_ID_Instr   = r.ins;
      MD_Start      = r.mds;
      Redirect      = r.rd;
   endtask

   task automatic test_reset();
      row_t v [4];
      v = '{'{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b1, S_RUN},
            '{1'b1, 5'd3, ADD123, 1'b1, 1'b1, 1'b1, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, MFLO8,  1'b0, 1'b0, 1'b0, S_RUN}};
      for (int i = 0; i < 4; i++) begin
         apply(v[i]);
         @(negedge Clk);
         total++;
         if (outs() !== v[i].exp) begin
            bad++;
            $display("FAIL reset[%0d] got=%b want=%b", i, outs(), v[i].exp);
         end
      end
   endtask

   task automatic test_load_use();
      row_t v [4];
      v = '{'{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_RUN}};
      for (int i = 0; i < 4; i++) begin
         apply(v[i]);
         @(negedge Clk);
         total++;
         if (outs() !== v[i].exp) begin
            bad++;
            $display("FAIL load_use[%0d] got=%b want=%b", i, outs(), v[i].exp);
         end
      end
   endtask

   task automatic test_no_hazard();
      row_t v [4];
      v = '{'{1'b1, 5'd0, ADD100, 1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b1, 5'd5, ADD123, 1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b1, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_RUN}};
      for (int i = 0; i < 4; i++) begin
         apply(v[i]);
         @(negedge Clk);
         total++;
         if (outs() !== v[i].exp) begin
            bad++;
            $display("FAIL no_hazard[%0d] got=%b want=%b", i, outs(), v[i].exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      row_t v [5];
      v = '{'{1'b1, 5'd2, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd2, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_RUN}};
      for (int i = 0; i < 5; i++) begin
         apply(v[i]);
         @(negedge Clk);
         total++;
         if (outs() !== v[i].exp) begin
            bad++;
            $display("FAIL back_to_back[%0d] got=%b want=%b", i, outs(), v[i].exp);
         end
      end
   endtask

   task automatic test_md();
      row_t v [20];
      v = '{'{1'b0, 5'd0, MFLO8,  1'b1, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, MFLO8,  1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, MFLO8,  1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, MFLO8,  1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, MFLO8,  1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, MFLO8,  1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b1, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, ADD123, 1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, MULT45, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, ORI67,  1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, MFHI9,  1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, DIVU45, 1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b1, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b1, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, DIVU45, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, DIVU45, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, DIVU45, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, DIVU45, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, DIVU45, 1'b0, 1'b0, 1'b0, S_RUN}};
      for (int i = 0; i < 20; i++) begin
         apply(v[i]);
         @(negedge Clk);
         total++;
         if (outs() !== v[i].exp) begin
            bad++;
            $display("FAIL md[%0d] got=%b want=%b", i, outs(), v[i].exp);
         end
      end
   endtask

   task automatic test_redirect_ld();
      row_t v [5];
      v = '{'{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd3, ADD123, 1'b0, 1'b1, 1'b0, S_RDR},
            '{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_FL},
            '{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_FL},
            '{1'b0, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_RUN}};
      for (int i = 0; i < 5; i++) begin
         apply(v[i]);
         @(negedge Clk);
         total++;
         if (outs() !== v[i].exp) begin
            bad++;
            $display("FAIL redirect_ld[%0d] got=%b want=%b", i, outs(), v[i].exp);
         end
      end
   endtask

   task automatic test_redirect_in_flush();
      row_t v [6];
      v = '{'{1'b1, 5'd3, ADD123, 1'b0, 1'b1, 1'b0, S_RDR},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_FL},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b1, 1'b0, S_RDR},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_FL},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_FL},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_RUN}};
      for (int i = 0; i < 6; i++) begin
         apply(v[i]);
         @(negedge Clk);
         total++;
         if (outs() !== v[i].exp) begin
            bad++;
            $display("FAIL redirect_in_flush[%0d] got=%b want=%b", i, outs(), v[i].exp);
         end
      end
   endtask

   task automatic test_reset_abort();
      row_t v [6];
      v = '{'{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b1, S_RUN},
            '{1'b0, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b1, 1'b0, S_RDR},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b1, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_RUN}};
      for (int i = 0; i < 6; i++) begin
         apply(v[i]);
         @(negedge Clk);
         total++;
         if (outs() !== v[i].exp) begin
            bad++;
            $display("FAIL reset_abort[%0d] got=%b want=%b", i, outs(), v[i].exp);
         end
      end
   endtask

`ifdef HAZARD_STATS_EN
   task automatic test_stats();
      row_t v [10];
      v = '{'{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b1, S_RUN},
            '{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, NOP,    1'b1, 1'b0, 1'b0, S_RUN},
            '{1'b0, 5'd0, MFLO8,  1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b1, 1'b0, S_RDR},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_FL},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b0, 1'b0, S_FL},
            '{1'b1, 5'd3, ADD123, 1'b0, 1'b0, 1'b0, S_STL},
            '{1'b0, 5'd0, NOP,    1'b0, 1'b1, 1'b0, S_RDR}};
      for (int i = 0; i < 10; i++) begin
         apply(v[i]);
         @(negedge Clk);
         if (i == 1) begin
            total++;
            if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
               bad++;
               $display("FAIL stats_reset got=%0d/%0d want=0/0", StallCount, FlushCount);
            end
         end
         if (i == 6) begin
            total++;
            if (StallCount !== 32'd3 || FlushCount !== 32'd1) begin
               bad++;
               $display("FAIL stats_count got=%0d/%0d want=3/1", StallCount, FlushCount);
            end
         end
         // Preload both counters to full scale across one edge.
         if (i == 7) begin
            force dut.stall_count_q = 32'hFFFF_FFFF;
            force dut.flush_count_q = 32'hFFFF_FFFF;
         end
         if (i == 8) begin
            release dut.stall_count_q;
            release dut.flush_count_q;
         end
      end
      tick();
      Redirect = 1'b0;
      @(negedge Clk);
      total++;
      if (StallCount !== 32'hFFFF_FFFF || FlushCount !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL stats_saturate got=%h/%h want=ffffffff/ffffffff", StallCount, FlushCount);
      end
   endtask
`endif

   initial begin
      Reset         = 1'b1;
      IF_ID_Instr   = NOP;
      ID_EX_Rt      = 5'd0;
      ID_EX_MemRead = 1'b0;
      MD_Start      = 1'b0;
      Redirect      = 1'b0;
      test_reset();
      test_load_use();
      test_no_hazard();
      test_back_to_back();
      test_md();
      test_redirect_ld();
      test_redirect_in_flush();
      test_reset_abort();
`ifdef HAZARD_STATS_EN
      test_stats();
`endif
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_v2.md
# hazard_ctrl_v2

Parametrised pipeline hazard controller for the 5-stage MIPS datapath, successor to the combinational hazard unit. Sits beside the IF/ID and ID/EX pipeline registers and drives PC write-enable, IF/ID write-enable and both flush lines. Adds the following over the first generation:
- multi-cycle load-use stalls
- a tracked multiply/divide busy window
- configurable post-redirect flush depth
- optional stall/flush statistics

## Interface
Parameters:
- REG_W, 5, register-address width
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..3)
- MD_LAT, 4, cycles the mult/div unit stays busy after MD_Start (1..32)
- EXTRA_FLUSH, 0, additional IF/ID-only flush cycles after a redirect (0..3)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- IF_ID_Instr  in  32  instruction currently in ID
- ID_EX_Rt  in  REG_W  destination register of the instruction in EX
- ID_EX_MemRead  in  1  instruction in EX is a load
- MD_Start  in  1  mult/div issued from EX this cycle (one-cycle pulse)
- Redirect  in  1  EX resolved a taken branch, j, jal or jr this cycle
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register enable
- IF_ID_Flush  out  1  zero IF/ID on next edge
- ID_EX_Flush  out  1  zero ID/EX controls on next edge (bubble)
- StallActive  out  1  a stall bubble is being inserted this cycle
- StallCount  out  32  stall cycles, saturating (HAZARD_STATS_EN only)
- FlushCount  out  32  redirect events, saturating (HAZARD_STATS_EN only)

## Operation
FSM states: RUN, LD_STALL, FLUSH.

Load-use detection (combinational):
- hazard when ID_EX_MemRead=1 and ID_EX_Rt≠0 and ID_EX_Rt equals IF_ID_Instr[25:21] or IF_ID_Instr[20:16].

MD hazard:
- MdCnt is loaded with MD_LAT on MD_Start and decrements to 0.
- Hazard when MdCnt≠0 and the ID instruction is mfhi/mflo (opcode 000000, funct 010000/010010) or a new mult/div (funct 011000..011011).

Stall cycle outputs:
- PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, StallActive=1, IF_ID_Flush=0.

State transitions:
- RUN, load-use hazard: stall this cycle. If LOAD_STALL>1, go to LD_STALL with LdCnt=LOAD_STALL-1.
- LD_STALL: stall every cycle. LdCnt decrements each cycle; return to RUN on the cycle LdCnt reaches 0.
- MD hazard: stall in any state while the condition holds. It does not change FSM state.
- Redirect, any state: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_ID_Write=1, StallActive=0 this cycle. Any LD_STALL is abandoned (wrong-path instruction).
- After Redirect with EXTRA_FLUSH>0: enter FLUSH with FlCnt=EXTRA_FLUSH. Otherwise go to RUN.
- FLUSH: IF_ID_Flush=1 only. PCWrite=1. Load-use and MD hazards are ignored, because the ID slot is being flushed. Exit to RUN when FlCnt reaches 0.

Priority: Redirect > FLUSH > load-use/LD_STALL > MD hazard.
- MdCnt keeps counting through redirects and flushes; the issued op is real.
- A Redirect arriving during FLUSH reloads FlCnt=EXTRA_FLUSH.
- MD_Start arriving while MdCnt≠0 reloads MdCnt=MD_LAT.

## Timing
- All hazard outputs are combinational from current state, counters and inputs; zero-cycle response, as in the first generation.
- State, LdCnt, FlCnt and MdCnt update on the rising edge of Clk.
- Load-use with LOAD_STALL=N: exactly N consecutive stall cycles, starting in the detection cycle.
- MD window: MD_Start at edge k blocks dependent ID instructions for cycles k+1 … k+MD_LAT.
- While Reset=1: state=RUN, all counters=0, PCWrite=1, IF_ID_Write=1, both flushes=0, StallActive=0, stats=0.
- Reset mid-stall or mid-flush aborts it on the next edge.

## Configuration
- HAZARD_STATS_EN defined:
  - StallCount increments each cycle StallActive=1.
  - FlushCount increments each cycle Redirect=1.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
- HAZARD_STATS_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package hazard_pkg holds:
  - opcode/funct constants: OP_RTYPE, FN_MFHI, FN_MFLO, FN_MULT..FN_DIVU
  - FSM state encoding: RUN=2'd0, LD_STALL=2'd1, FLUSH=2'd2
- Sub-module hazard_downcnt: loadable, saturating-at-zero down counter with a done flag. It is instantiated for LdCnt, FlCnt and MdCnt, each sized to its parameter.

## Test plan
- LOAD_STALL=2; lw into $3 in EX, ID holds add $1,$2,$3 → PCWrite=0 and ID_EX_Flush=1 for exactly 2 cycles, then PCWrite=1.
- ID_EX_Rt=0 with ID_EX_MemRead=1 and the ID instruction reading $0 → no stall.
- MD_LAT=4; MD_Start at cycle 10, mflo in ID from cycle 11 → stalls cycles 11–14, proceeds at cycle 15.
- EXTRA_FLUSH=2; Redirect during LD_STALL:
  - redirect cycle: both flushes=1, PCWrite=1;
  - next 2 cycles: IF_ID_Flush=1 only;
  - LD_STALL abandoned.
- Reset asserted mid-LD_STALL → next cycle all outputs at reset values and state=RUN.
- With HAZARD_STATS_EN: 3 stall cycles and 1 redirect → StallCount=3, FlushCount=1. Preloaded saturation test holds 0xFFFFFFFF.
